// File: rtl/sio_frame_ctrl.sv
// Framed byte sequencer between a host and a serial core: a buffered TX frame path and a counted RX frame path.
// Optional per-frame end-around-carry checksum byte on both paths, compiled in when SIO_CHKSUM_EN is defined.
module sio_frame_ctrl (
  input  logic       clk,
  input  logic       nrst,
  input  logic       ce,
  input  logic       tx_we,
  input  logic [7:0] tx_wdata,
  input  logic [4:0] tx_len,
  input  logic       tx_go,
  output logic       tx_busy,
  output logic       tx_done,
  input  logic       sdoCompl,
  input  logic       sdoFinish,
  output logic       AddrDw,
  output logic [7:0] Dw,
  input  logic       rx_arm,
  input  logic [4:0] rx_len,
  input  logic       sdiCompl,
  input  logic       framerr,
  input  logic [7:0] Dr,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic [1:0] rx_err
);

  function automatic logic [7:0] cks_add(input logic [7:0] sum, input logic [7:0] data);
    logic [8:0] total;
    total = {1'b0, sum} + {1'b0, data};
    return total[7:0] + {7'd0, total[8]};
  endfunction

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_LOAD  = 3'd1,
    TX_WAIT  = 3'd2,
`ifdef SIO_CHKSUM_EN
    TX_CHK   = 3'd3,
`endif
    TX_DRAIN = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
`ifdef SIO_CHKSUM_EN
    RX_CHK  = 2'd2,
`endif
    RX_DATA = 2'd1
  } rx_state_t;

  tx_state_t  tx_state_r;
  logic [7:0] tx_buf_r [16];
  logic [3:0] tx_wptr_r;
  logic [4:0] tx_idx_r;
  logic [4:0] tx_len_r;
  logic [7:0] tx_sum_r;
  logic       tx_buf_we_s;
  logic       tx_len_ok_s;

  rx_state_t  rx_state_r;
  logic [4:0] rx_cnt_r;
  logic [4:0] rx_len_r;
  logic [7:0] rx_sum_r;
  logic       rx_frm_err_r;
  logic       rx_len_ok_s;
`ifdef SIO_CHKSUM_EN
  logic       tx_chk_sent_r;
  logic       rx_chk_err_r;
`endif

  // Buffer write enable and frame-length range qualification.
  always_comb begin
    tx_buf_we_s = ce & tx_we & (tx_state_r == TX_IDLE);
    tx_len_ok_s = (tx_len != 5'd0) && (tx_len <= 5'd16);
    rx_len_ok_s = (rx_len != 5'd0) && (rx_len <= 5'd16);
  end

  // TX byte buffer; contents survive reset.
  always_ff @(posedge clk) begin
    if (tx_buf_we_s) tx_buf_r[tx_wptr_r] <= tx_wdata;
  end

  // TX frame sequencer: one AddrDw per byte, each paced by sdoCompl.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_state_r    <= TX_IDLE;
      tx_wptr_r     <= 4'd0;
      tx_idx_r      <= 5'd0;
      tx_len_r      <= 5'd0;
      tx_sum_r      <= 8'd0;
      tx_busy       <= 1'b0;
      tx_done       <= 1'b0;
      AddrDw        <= 1'b0;
      Dw            <= 8'd0;
`ifdef SIO_CHKSUM_EN
      tx_chk_sent_r <= 1'b0;
`endif
    end else if (ce) begin
      AddrDw  <= 1'b0;
      tx_done <= 1'b0;
      if (tx_buf_we_s) tx_wptr_r <= tx_wptr_r + 4'd1;
      case (tx_state_r)
        TX_IDLE: begin
          if (tx_go && tx_len_ok_s) begin
            tx_len_r   <= tx_len;
            tx_idx_r   <= 5'd0;
            tx_sum_r   <= 8'd0;
            tx_busy    <= 1'b1;
            tx_state_r <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          AddrDw     <= 1'b1;
          Dw         <= tx_buf_r[tx_idx_r[3:0]];
          tx_sum_r   <= cks_add(tx_sum_r, tx_buf_r[tx_idx_r[3:0]]);
          tx_idx_r   <= tx_idx_r + 5'd1;
          tx_state_r <= TX_WAIT;
        end
        TX_WAIT: begin
          if (sdoCompl) begin
            if (tx_idx_r < tx_len_r) begin
              tx_state_r <= TX_LOAD;
            end else begin
`ifdef SIO_CHKSUM_EN
              tx_chk_sent_r <= 1'b0;
              tx_state_r    <= TX_CHK;
`else
              tx_state_r    <= TX_DRAIN;
`endif
            end
          end
        end
`ifdef SIO_CHKSUM_EN
        TX_CHK: begin
          if (!tx_chk_sent_r) begin
            AddrDw        <= 1'b1;
            Dw            <= tx_sum_r;
            tx_chk_sent_r <= 1'b1;
          end else if (sdoCompl) begin
            tx_state_r <= TX_DRAIN;
          end
        end
`endif
        TX_DRAIN: begin
          // Frame is complete only once the shifter has emptied the last byte.
          if (sdoFinish) begin
            tx_done    <= 1'b1;
            tx_busy    <= 1'b0;
            tx_wptr_r  <= 4'd0;
            tx_state_r <= TX_IDLE;
          end
        end
        default: begin
          tx_busy    <= 1'b0;
          tx_state_r <= TX_IDLE;
        end
      endcase
    end
  end

  // RX frame sequencer: counts received bytes and checks the trailing checksum.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_state_r   <= RX_IDLE;
      rx_cnt_r     <= 5'd0;
      rx_len_r     <= 5'd0;
      rx_sum_r     <= 8'd0;
      rx_frm_err_r <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= 8'd0;
      rx_done      <= 1'b0;
`ifdef SIO_CHKSUM_EN
      rx_chk_err_r <= 1'b0;
`endif
    end else if (ce) begin
      rx_valid <= 1'b0;
      rx_done  <= 1'b0;
      if (rx_arm) begin
        rx_frm_err_r <= 1'b0;
`ifdef SIO_CHKSUM_EN
        rx_chk_err_r <= 1'b0;
`endif
        rx_len_r     <= rx_len;
        rx_cnt_r     <= 5'd0;
        rx_sum_r     <= 8'd0;
        rx_state_r   <= rx_len_ok_s ? RX_DATA : RX_IDLE;
      end else begin
        if (framerr && (rx_state_r != RX_IDLE)) rx_frm_err_r <= 1'b1;
        case (rx_state_r)
          RX_IDLE: rx_state_r <= RX_IDLE;
          RX_DATA: begin
            if (sdiCompl) begin
              rx_data  <= Dr;
              rx_valid <= 1'b1;
              rx_sum_r <= cks_add(rx_sum_r, Dr);
              rx_cnt_r <= rx_cnt_r + 5'd1;
              if ((rx_cnt_r + 5'd1) == rx_len_r) begin
`ifdef SIO_CHKSUM_EN
                rx_state_r <= RX_CHK;
`else
                rx_done    <= 1'b1;
                rx_state_r <= RX_IDLE;
`endif
              end
            end
          end
`ifdef SIO_CHKSUM_EN
          RX_CHK: begin
            if (sdiCompl) begin
              if (Dr != rx_sum_r) rx_chk_err_r <= 1'b1;
              rx_done    <= 1'b1;
              rx_state_r <= RX_IDLE;
            end
          end
`endif
          default: rx_state_r <= RX_IDLE;
        endcase
      end
    end
  end

`ifdef SIO_CHKSUM_EN
  assign rx_err = {rx_chk_err_r, rx_frm_err_r};
`else
  assign rx_err = {1'b0, rx_frm_err_r};
`endif

endmodule

// File: tb/tb_sio_frame_ctrl.sv
// Self-checking bench for sio_frame_ctrl: vector table, hand sequences and a randomized reference-model run.
// Expectations follow SIO_CHKSUM_EN the same way the design build does.
module tb_sio_frame_ctrl;

`ifdef SIO_CHKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic       clk;
  logic       nrst;
  logic       ce = 1'b1;
  logic       tx_we, tx_go, sdoCompl, sdoFinish, rx_arm, sdiCompl, framerr;
  logic [7:0] tx_wdata, Dr;
  logic [4:0] tx_len, rx_len;
  logic       tx_busy, tx_done, AddrDw, rx_valid, rx_done;
  logic [7:0] Dw, rx_data;
  logic [1:0] rx_err;

  sio_frame_ctrl dut (
    .clk(clk), .nrst(nrst), .ce(ce),
    .tx_we(tx_we), .tx_wdata(tx_wdata), .tx_len(tx_len), .tx_go(tx_go),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .sdoCompl(sdoCompl), .sdoFinish(sdoFinish), .AddrDw(AddrDw), .Dw(Dw),
    .rx_arm(rx_arm), .rx_len(rx_len), .sdiCompl(sdiCompl), .framerr(framerr), .Dr(Dr),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         ce_mode  = 0;   // 0: ce high, 1: random, 2: ce low
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         tx_done_cnt = 0;
  int         rx_done_cnt = 0;
  bit         ce_s;
  logic [7:0] dat[16];
  logic [7:0] exp_tx[17];

  typedef struct {
    logic [7:0] d0, d1, d2, cks;
    bit         frm;
    logic [1:0] err_chk, err_nochk;
  } rx_vec_t;
  rx_vec_t vec[6];

  always @(negedge clk)
    ce = (ce_mode == 0) ? 1'b1 : (ce_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;

  // Record every output event once per active machine cycle
  always @(posedge clk) begin
    ce_s = ce;
    #1;
    if (nrst === 1'b1 && ce_s) begin
      if (AddrDw) tx_q.push_back(Dw);
      if (tx_done) tx_done_cnt++;
      if (rx_valid) rx_q.push_back(rx_data);
      if (rx_done) rx_done_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic ce_tick();
    do @(posedge clk); while (ce !== 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_tx(input int target);
    int t = 0;
    while (tx_q.size() < target && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (tx_q.size() < target) timeout_fail("addrdw_wait");
  endtask

  task automatic wait_tx_done(input int target);
    int t = 0;
    while (tx_done_cnt < target && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (tx_done_cnt < target) timeout_fail("tx_done_wait");
  endtask

  task automatic tx_load(input int n);
    tx_we = 1'b1;
    for (int i = 0; i < n; i++) begin
      tx_wdata = dat[i];
      ce_tick();
    end
    tx_we = 1'b0;
  endtask

  task automatic tx_start(input int len);
    tx_len = 5'(len);
    tx_go  = 1'b1;
    ce_tick();
    tx_go  = 1'b0;
  endtask

  task automatic tx_answer(input int base, input int n);
    for (int k = 1; k <= n; k++) begin
      wait_tx(base + k);
      sdoCompl = 1'b1;
      ce_tick();
      sdoCompl = 1'b0;
    end
  endtask

  // Reference checksum: ones'-complement style fold of the plain byte sum.
  function automatic logic [7:0] ref_cks(input int n);
    int tot = 0;
    for (int i = 0; i < n; i++) tot += int'(dat[i]);
    while (tot > 255) tot = (tot & 255) + (tot >> 8);
    return 8'(tot);
  endfunction

  task automatic tx_compare(input string tag, input int base, input int len);
    int n = len + CHK;
    for (int i = 0; i < len; i++) exp_tx[i] = dat[i];
    if (CHK != 0) exp_tx[len] = ref_cks(len);
    check({tag, "_addrdw_count"}, 32'(tx_q.size() - base), 32'(n));
    if (tx_q.size() - base == n)
      for (int i = 0; i < n; i++) check({tag, "_dw"}, 32'(tx_q[base + i]), 32'(exp_tx[i]));
  endtask

  task automatic rx_arm_len(input int len);
    rx_len = 5'(len);
    rx_arm = 1'b1;
    ce_tick();
    rx_arm = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input bit fe);
    Dr       = b;
    sdiCompl = 1'b1;
    framerr  = fe;
    ce_tick();
    sdiCompl = 1'b0;
    framerr  = 1'b0;
  endtask

  task automatic rx_compare(input string tag, input int rbase, input int dbase, input int len,
                            input logic [1:0] exp_err);
    check({tag, "_valid_count"}, 32'(rx_q.size() - rbase), 32'(len));
    if (rx_q.size() - rbase == len)
      for (int i = 0; i < len; i++) check({tag, "_data"}, 32'(rx_q[rbase + i]), 32'(dat[i]));
    check({tag, "_done_count"}, 32'(rx_done_cnt - dbase), 32'd1);
    check({tag, "_err"}, 32'(rx_err), 32'(exp_err));
  endtask

  initial begin
    int base, dbase, rbase, len, fe_idx;
    bit bad;
    logic [1:0] e;
    logic [7:0] ck;

    vec[0] = '{8'h31, 8'h52, 8'h00, 8'h83, 1'b0, 2'b00, 2'b00};
    vec[1] = '{8'h31, 8'h52, 8'h00, 8'h84, 1'b1, 2'b11, 2'b01};
    vec[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 2'b00, 2'b00};
    vec[3] = '{8'h80, 8'h80, 8'h01, 8'h02, 1'b0, 2'b00, 2'b00};
    vec[4] = '{8'h80, 8'h80, 8'h01, 8'h03, 1'b0, 2'b10, 2'b00};
    vec[5] = '{8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 2'b11, 2'b01};

    nrst = 1'b0; tx_we = 1'b0; tx_go = 1'b0; sdoCompl = 1'b0; sdoFinish = 1'b1;
    rx_arm = 1'b0; sdiCompl = 1'b0; framerr = 1'b0; tx_wdata = 8'd0; Dr = 8'd0;
    tx_len = 5'd0; rx_len = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_tx_outs", {29'd0, tx_busy, tx_done, AddrDw}, 32'd0);
    check("reset_dw", 32'(Dw), 32'd0);
    check("reset_rx_outs", {20'd0, rx_valid, rx_done, rx_err, rx_data}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Two-byte frame with a carry-producing checksum; done waits for sdoFinish
    sdoFinish = 1'b0;
    dat[0] = 8'hFF; dat[1] = 8'h01;
    base = tx_q.size(); dbase = tx_done_cnt;
    tx_load(2);
    tx_start(2);
    check("tx_busy_set", 32'(tx_busy), 32'd1);
    tx_answer(base, 2 + CHK);
    repeat (4) ce_tick();
    check("tx_done_held_by_finish", 32'(tx_done_cnt - dbase), 32'd0);
    check("tx_busy_in_drain", 32'(tx_busy), 32'd1);
    sdoFinish = 1'b1;
    wait_tx_done(dbase + 1);
    tx_compare("tx_ff01", base, 2);
    if (CHK != 0) check("tx_ff01_cks_const", 32'(tx_q[base + 2]), 32'h01);
    check("tx_busy_clear", 32'(tx_busy), 32'd0);

    // RX vector table: three data bytes plus checksum byte, optional framing error on byte 2
    for (int v = 0; v < 6; v++) begin
      rbase = rx_q.size(); dbase = rx_done_cnt;
      dat[0] = vec[v].d0; dat[1] = vec[v].d1; dat[2] = vec[v].d2;
      rx_arm_len(3);
      rx_byte(vec[v].d0, 1'b0);
      rx_byte(vec[v].d1, vec[v].frm);
      rx_byte(vec[v].d2, 1'b0);
      rx_byte(vec[v].cks, 1'b0);
      ce_tick();
      rx_compare("rx_vec", rbase, dbase, 3, (CHK != 0) ? vec[v].err_chk : vec[v].err_nochk);
    end

    // Invalid tx_go lengths and tx_go while busy are ignored
    base = tx_q.size(); dbase = tx_done_cnt;
    tx_start(0);
    repeat (3) ce_tick();
    check("tx_len0_busy", 32'(tx_busy), 32'd0);
    tx_start(17);
    repeat (3) ce_tick();
    check("tx_len17_busy", 32'(tx_busy), 32'd0);
    check("tx_badlen_no_addrdw", 32'(tx_q.size() - base), 32'd0);
    dat[0] = 8'hA5; dat[1] = 8'h5A;
    tx_load(2);
    tx_start(2);
    wait_tx(base + 1);
    tx_start(5);
    tx_answer(base, 2 + CHK);
    wait_tx_done(dbase + 1);
    repeat (4) ce_tick();
    tx_compare("tx_go_busy", base, 2);
    check("tx_go_busy_done", 32'(tx_done_cnt - dbase), 32'd1);
    check("tx_go_busy_idle", 32'(tx_busy), 32'd0);

    // Strobes while ce is low are ignored
    rbase = rx_q.size(); dbase = rx_done_cnt;
    rx_arm_len(1);
    ce_mode = 2;
    @(negedge clk);
    sdiCompl = 1'b1; framerr = 1'b1; Dr = 8'hAA;
    repeat (4) @(negedge clk);
    sdiCompl = 1'b0; framerr = 1'b0;
    ce_mode = 0;
    repeat (2) @(negedge clk);
    check("ce_low_no_valid", 32'(rx_q.size() - rbase), 32'd0);
    check("ce_low_no_err", 32'(rx_err), 32'd0);
    dat[0] = 8'h3C;
    rx_byte(8'h3C, 1'b0);
    if (CHK != 0) rx_byte(8'h3C, 1'b0);
    ce_tick();
    rx_compare("ce_low_then_byte", rbase, dbase, 1, 2'b00);

    // Reset during a 16-byte frame after byte 3, with RX mid-frame too
    for (int i = 0; i < 16; i++) dat[i] = 8'h10 + 8'(i);
    base = tx_q.size(); dbase = tx_done_cnt; rbase = rx_q.size();
    tx_load(16);
    tx_start(16);
    tx_answer(base, 2);
    wait_tx(base + 3);
    rx_arm_len(4);
    rx_byte(8'h77, 1'b1);
    nrst = 1'b0;
    #1;
    check("midreset_tx_outs", {29'd0, tx_busy, tx_done, AddrDw}, 32'd0);
    check("midreset_dw", 32'(Dw), 32'd0);
    check("midreset_rx_outs", {20'd0, rx_valid, rx_done, rx_err, rx_data}, 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sdoCompl = 1'b1; sdiCompl = 1'b1; Dr = 8'h55;
      ce_tick();
    end
    sdoCompl = 1'b0; sdiCompl = 1'b0;
    repeat (2) ce_tick();
    check("midreset_addrdw_count", 32'(tx_q.size() - base), 32'd3);
    check("midreset_no_tx_done", 32'(tx_done_cnt - dbase), 32'd0);
    check("midreset_rx_count", 32'(rx_q.size() - rbase), 32'd1);
    check("midreset_idle", {30'd0, tx_busy, rx_valid}, 32'd0);

    // Randomized TX frames under random ce, checked against the reference checksum
    ce_mode = 1;
    for (int f = 0; f < 20; f++) begin
      len = (f == 0) ? 16 : (f == 1) ? 1 : int'($urandom_range(1, 16));
      for (int i = 0; i < len; i++) dat[i] = 8'($urandom_range(0, 255));
      base = tx_q.size(); dbase = tx_done_cnt;
      tx_load(len);
      tx_start(len);
      tx_answer(base, len + CHK);
      wait_tx_done(dbase + 1);
      tx_compare("rand_tx", base, len);
      check("rand_tx_busy", 32'(tx_busy), 32'd0);
    end

    // Randomized RX frames with random framing errors and checksum corruption
    for (int f = 0; f < 20; f++) begin
      len = (f == 0) ? 16 : (f == 1) ? 1 : int'($urandom_range(1, 16));
      for (int i = 0; i < len; i++) dat[i] = 8'($urandom_range(0, 255));
      fe_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      bad = ($urandom_range(0, 2) == 0);
      rbase = rx_q.size(); dbase = rx_done_cnt;
      rx_arm_len(len);
      for (int i = 0; i < len; i++) rx_byte(dat[i], (i == fe_idx));
      ck = ref_cks(len) ^ (bad ? 8'h5A : 8'h00);
      if (CHK != 0) rx_byte(ck, 1'b0);
      ce_tick();
      e[1] = (CHK != 0) && bad;
      e[0] = (fe_idx >= 0);
      rx_compare("rand_rx", rbase, dbase, len, e);
    end
    ce_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sio_frame_ctrl.md
SIO_FRAME_CTRL -- requirements
Module: sio_frame_ctrl

Interface
REQ-001 SHALL provide these ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock; all logic on rising edge.
- nrst  in  1  reset; asynchronous assert, active-low.
- ce  in  1  machine-cycle enable; state advances only when ce=1.
- tx_we  in  1  host write strobe into TX buffer.
- tx_wdata  in  8  host TX byte.
- tx_len  in  5  TX frame length in data bytes, 1..16.
- tx_go  in  1  start TX frame.
- tx_busy  out  1  TX frame in progress.
- tx_done  out  1  one-ce pulse at TX frame end.
- sdoCompl  in  1  serial core output-register-free strobe.
- sdoFinish  in  1  serial core shifter idle.
- AddrDw  out  1  one-ce write strobe to serial core SEROUT.
- Dw  out  8  byte to serial core.
- rx_arm  in  1  arm RX frame capture.
- rx_len  in  5  RX frame length in data bytes, 1..16.
- sdiCompl  in  1  serial core byte-received strobe.
- framerr  in  1  serial core framing-error strobe.
- Dr  in  8  serial core received byte.
- rx_valid  out  1  one-ce pulse; rx_data is valid.
- rx_data  out  8  received data byte.
- rx_done  out  1  one-ce pulse at RX frame end.
- rx_err  out  2  [0] framing error seen, [1] checksum mismatch; held until next rx_arm.
REQ-002 SHALL use one clock, clk; reset nrst is asynchronous and active-low.

Function
REQ-003 SHALL hold a 16x8 TX buffer with a 4-bit write pointer. Each tx_we in TX IDLE writes tx_wdata and increments the pointer, wrapping 15->0. tx_we is ignored while tx_busy.
REQ-004 SHALL implement TX FSM states IDLE, LOAD, WAIT, CHK, DRAIN.
REQ-005 IDLE->LOAD on tx_go with tx_len in 1..16: latch tx_len, reset the read index, clear the checksum, and set tx_busy. tx_go with tx_len=0 or >16 SHALL be ignored.
REQ-006 LOAD: drive Dw=buf[idx] and AddrDw=1 for exactly one ce cycle, add the byte to the checksum, increment idx, then go to WAIT.
REQ-007 WAIT: on sdoCompl, go to LOAD if idx<len. Otherwise go to CHK (checksum enabled) or DRAIN.
REQ-008 CHK: write the checksum byte with a single AddrDw, then wait for sdoCompl, then go to DRAIN.
REQ-009 DRAIN: when sdoFinish=1, pulse tx_done, clear tx_busy, clear the write pointer, and return to IDLE. tx_go during any non-IDLE state SHALL be ignored.
REQ-010 Checksum arithmetic: sum = sum + byte + carry-out of that 9-bit add (end-around carry), 8-bit result, initial value 0x00.
REQ-011 SHALL implement RX FSM states IDLE, DATA, CHK.
- rx_arm in any state: clears rx_err, latches rx_len, clears count and checksum, goes to DATA.
- rx_len=0 or >16: FSM stays IDLE.
REQ-012 DATA: each sdiCompl captures Dr, presents it on rx_data with an rx_valid pulse in the next ce cycle, accumulates the checksum, and increments count. After count==len, go to CHK (enabled) or pulse rx_done and go to IDLE.
REQ-013 CHK: on the next sdiCompl, compare Dr to the accumulated checksum, set rx_err[1] on mismatch, pulse rx_done, and go to IDLE. This byte SHALL NOT produce rx_valid.
REQ-014 A framerr strobe while RX is not IDLE SHALL set rx_err[0]; the byte still counts. sdiCompl or framerr in RX IDLE SHALL be ignored.
REQ-015 TX and RX SHALL operate independently; simultaneous sdoCompl and sdiCompl are both serviced in the same cycle.
REQ-016 Strobes arriving with ce=0 SHALL be ignored; inputs are sampled only when ce=1.

Reset
REQ-017 nrst low SHALL force both FSMs to IDLE and clear the pointers, counts and checksums. All outputs SHALL be 0, including tx_busy, tx_done, AddrDw, Dw, rx_valid, rx_data, rx_done and rx_err. Buffer contents are don't-care.
REQ-018 Reset asserted mid-frame SHALL abort without a trailing AddrDw, tx_done or rx_done. After release, the block SHALL wait for a new tx_go or rx_arm.

Configuration
REQ-019 Macro SIO_CHKSUM_EN:
- Defined: CHK states exist; TX appends the checksum byte (len+1 AddrDw pulses); RX expects len+1 bytes and sets rx_err[1] on mismatch.
- Undefined: CHK states removed; TX sends exactly len bytes; RX completes after len bytes; rx_err[1] is tied to 0.

Verification
REQ-020 Write 0xFF,0x01, tx_len=2, tx_go, answer each AddrDw with sdoCompl -> AddrDw data 0xFF, 0x01, 0x01 (checksum); tx_done after sdoFinish=1.
REQ-021 rx_arm with rx_len=3; sdiCompl with Dr=0x31,0x52,0x00, then checksum 0x83 -> three rx_valid pulses with those bytes; rx_done; rx_err=00.
REQ-022 Same as REQ-021 but checksum byte 0x84, plus a framerr strobe on byte 2 -> rx_err=11 after rx_done.
REQ-023 tx_len=0 tx_go, and tx_go while busy -> no AddrDw, no state change; the in-flight frame completes unaffected.
REQ-024 nrst pulsed low during TX WAIT after byte 3 of 16 -> all outputs 0 immediately; no further AddrDw after release.
REQ-025 Build without SIO_CHKSUM_EN, rerun REQ-020 -> exactly two AddrDw pulses (0xFF, 0x01).
